// File: rtl/n101_i2c_slave_ctrl.sv
// I2C target byte controller: START/STOP detect, 7-bit address match, write RX with ACK, read TX with ACK sampling.
// Optional SCL stretching on read with an empty tx buffer when I2C_SLAVE_STRETCH_EN is defined.
module n101_i2c_slave_ctrl #(
  parameter int unsigned SU_CYC = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  input  logic [6:0] slv_addr,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       scl_o,
  output logic       sda_o,
  output logic       scl_oen,
  output logic       sda_oen,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_req,
  output logic       busy,
  output logic       addressed,
  output logic       rw,
  output logic       nack_rcvd
);

  if (SU_CYC < 1 || SU_CYC > 255) begin : g_su_cyc_range
    $error("SU_CYC must be in 1..255");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_ADDR_ACK, S_RX, S_RX_ACK, S_TX, S_TX_ACK
  } state_e;

  logic scl_meta_q, scl_s_q, scl_d_q;
  logic sda_meta_q, sda_s_q, sda_d_q;

  state_e     state_q;
  logic [3:0] bitcnt_q;
  logic [7:0] shift_q;
  logic [7:0] txshift_q;
  logic [7:0] txbuf_q;
  logic       txfull_q;
  logic       ack_q;
  logic       sda_oen_q;
  logic [7:0] rx_data_q;
  logic       rx_valid_q;
  logic       busy_q;
  logic       addressed_q;
  logic       rw_q;
  logic       nack_q;
`ifdef I2C_SLAVE_STRETCH_EN
  logic       scl_oen_q;
  logic       wait_q;
  logic       su_q;
  logic [7:0] su_cnt_q;
`endif

  logic scl_rise, scl_fall, start_det, stop_det, tx_start;

  // Bus lines idle high, so the synchronisers reset to 1 to avoid a false START/STOP.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_meta_q <= 1'b1;
      scl_s_q    <= 1'b1;
      scl_d_q    <= 1'b1;
      sda_meta_q <= 1'b1;
      sda_s_q    <= 1'b1;
      sda_d_q    <= 1'b1;
    end else begin
      scl_meta_q <= scl_i;
      scl_s_q    <= scl_meta_q;
      scl_d_q    <= scl_s_q;
      sda_meta_q <= sda_i;
      sda_s_q    <= sda_meta_q;
      sda_d_q    <= sda_s_q;
    end
  end

  assign scl_rise  = scl_s_q & ~scl_d_q;
  assign scl_fall  = ~scl_s_q & scl_d_q;
  assign start_det = sda_d_q & ~sda_s_q & scl_s_q;
  assign stop_det  = ~sda_d_q & sda_s_q & scl_s_q;

  // Both the address ACK (read) and a master ACK on a read byte begin a new TX byte.
  assign tx_start = scl_fall & (((state_q == S_ADDR_ACK) & rw_q) | ((state_q == S_TX_ACK) & ack_q));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      bitcnt_q    <= '0;
      shift_q     <= '0;
      txshift_q   <= '1;
      txbuf_q     <= '0;
      txfull_q    <= 1'b0;
      ack_q       <= 1'b0;
      sda_oen_q   <= 1'b1;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      busy_q      <= 1'b0;
      addressed_q <= 1'b0;
      rw_q        <= 1'b0;
      nack_q      <= 1'b0;
`ifdef I2C_SLAVE_STRETCH_EN
      scl_oen_q   <= 1'b1;
      wait_q      <= 1'b0;
      su_q        <= 1'b0;
      su_cnt_q    <= '0;
`endif
    end else begin
      rx_valid_q <= 1'b0;
      nack_q     <= 1'b0;
      if (tx_valid) begin
        txbuf_q  <= tx_data;
        txfull_q <= 1'b1;
      end
      if (start_det) begin
        state_q     <= S_ADDR;
        bitcnt_q    <= '0;
        sda_oen_q   <= 1'b1;
        addressed_q <= 1'b0;
        busy_q      <= 1'b1;
`ifdef I2C_SLAVE_STRETCH_EN
        scl_oen_q   <= 1'b1;
        wait_q      <= 1'b0;
        su_q        <= 1'b0;
`endif
      end else if (stop_det) begin
        state_q     <= S_IDLE;
        sda_oen_q   <= 1'b1;
        addressed_q <= 1'b0;
        busy_q      <= 1'b0;
`ifdef I2C_SLAVE_STRETCH_EN
        scl_oen_q   <= 1'b1;
        wait_q      <= 1'b0;
        su_q        <= 1'b0;
`endif
      end else begin
        case (state_q)
          S_ADDR: begin
            if (scl_rise && bitcnt_q != 4'd8) begin
              shift_q  <= {shift_q[6:0], sda_s_q};
              bitcnt_q <= bitcnt_q + 4'd1;
            end else if (scl_fall && bitcnt_q == 4'd8) begin
              if (ena && shift_q[7:1] == slv_addr) begin
                sda_oen_q   <= 1'b0;
                rw_q        <= shift_q[0];
                addressed_q <= 1'b1;
                state_q     <= S_ADDR_ACK;
              end else begin
                state_q <= S_IDLE;
              end
            end
          end
          S_ADDR_ACK: begin
            if (scl_fall && !rw_q) begin
              sda_oen_q <= 1'b1;
              bitcnt_q  <= '0;
              state_q   <= S_RX;
            end
          end
          S_RX: begin
            if (scl_rise && bitcnt_q != 4'd8) begin
              shift_q  <= {shift_q[6:0], sda_s_q};
              bitcnt_q <= bitcnt_q + 4'd1;
            end else if (scl_fall && bitcnt_q == 4'd8) begin
              rx_data_q  <= shift_q;
              rx_valid_q <= 1'b1;
              sda_oen_q  <= 1'b0;
              state_q    <= S_RX_ACK;
            end
          end
          S_RX_ACK: begin
            if (scl_fall) begin
              sda_oen_q <= 1'b1;
              bitcnt_q  <= '0;
              state_q   <= S_RX;
            end
          end
          S_TX: begin
`ifdef I2C_SLAVE_STRETCH_EN
            if (wait_q) begin
              if (txfull_q) begin
                txshift_q <= txbuf_q;
                txfull_q  <= tx_valid;
                sda_oen_q <= txbuf_q[7];
                wait_q    <= 1'b0;
                su_q      <= 1'b1;
                su_cnt_q  <= 8'(SU_CYC - 1);
              end
            end else if (su_q) begin
              if (su_cnt_q == '0) begin
                su_q      <= 1'b0;
                scl_oen_q <= 1'b1;
              end else begin
                su_cnt_q <= su_cnt_q - 8'd1;
              end
            end else
`endif
            if (scl_fall) begin
              if (bitcnt_q == 4'd7) begin
                sda_oen_q <= 1'b1;
                state_q   <= S_TX_ACK;
              end else begin
                bitcnt_q  <= bitcnt_q + 4'd1;
                txshift_q <= {txshift_q[6:0], 1'b1};
                sda_oen_q <= txshift_q[6];
              end
            end
          end
          S_TX_ACK: begin
            if (scl_rise) begin
              ack_q <= ~sda_s_q;
            end else if (scl_fall && !ack_q) begin
              nack_q    <= 1'b1;
              sda_oen_q <= 1'b1;
              state_q   <= S_IDLE;
            end
          end
          default: ;
        endcase
        if (tx_start) begin
          state_q  <= S_TX;
          bitcnt_q <= '0;
          if (txfull_q) begin
            txshift_q <= txbuf_q;
            txfull_q  <= tx_valid;
            sda_oen_q <= txbuf_q[7];
          end else begin
            sda_oen_q <= 1'b1;
`ifdef I2C_SLAVE_STRETCH_EN
            scl_oen_q <= 1'b0;
            wait_q    <= 1'b1;
`else
            txshift_q <= 8'hFF;
`endif
          end
        end
      end
    end
  end

  assign scl_o     = 1'b0;
  assign sda_o     = 1'b0;
`ifdef I2C_SLAVE_STRETCH_EN
  assign scl_oen   = scl_oen_q;
`else
  assign scl_oen   = 1'b1;
`endif
  assign sda_oen   = sda_oen_q;
  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign tx_req    = ~txfull_q & addressed_q & rw_q;
  assign busy      = busy_q;
  assign addressed = addressed_q;
  assign rw        = rw_q;
  assign nack_rcvd = nack_q;

endmodule

// File: doc/n101_i2c_slave_ctrl.md
# n101_i2c_slave_ctrl

I2C target (slave) byte controller for the n101 peripheral subsystem. It is the responder counterpart of the n101 I2C master bit controller on the same open-drain bus. It detects START and STOP, matches a 7-bit address, receives write bytes and acknowledges them, and transmits read bytes while sampling the master's ACK/NACK. SCL clock stretching on read is optional.

## Interface
- SU_CYC, default 4: clk cycles SDA is held stable before SCL is released after a stretch (range 1..255).
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-high.
- ena  in  1  block enable; when 0, the address is never acknowledged.
- slv_addr  in  7  own 7-bit address.
- scl_i / sda_i  in  1  bus line inputs, asynchronous to clk.
- scl_o / sda_o  out  1  tied to constant 0.
- scl_oen / sda_oen  out  1  output enable, active-low; 0 pulls the line low.
- rx_data  out  8  last received data byte.
- rx_valid  out  1  one-cycle pulse; rx_data is valid in that cycle.
- tx_data  in  8  byte to transmit.
- tx_valid  in  1  loads tx_data into the internal tx buffer.
- tx_req  out  1  level; high while the tx buffer is empty inside a read transfer.
- busy  out  1  high from START to STOP on the bus (any address).
- addressed  out  1  high from own-address ACK to STOP or repeated START.
- rw  out  1  R/W bit of the last matched address.
- nack_rcvd  out  1  one-cycle pulse when the master NACKs a read byte.

## Operation
- Synchronization: scl_i and sda_i each pass through 2 flops to give sSCL and sSDA. The previous values are registered as dSCL and dSDA.
  - scl_rise = sSCL & ~dSCL; scl_fall = ~sSCL & dSCL.
  - START = dSDA & ~sSDA & sSCL; STOP = ~dSDA & sSDA & sSCL.
- Priority: START, then STOP, then SCL edges.
- START (including repeated START), from any state: go to ADDR, clear the bit counter, release SDA and SCL, clear addressed.
- STOP, from any state: go to IDLE, release both lines, clear addressed.
- State machine transitions:
  - IDLE: wait for START.
  - ADDR: shift sSDA in MSB first on each scl_rise. After the 8th bit, on the next scl_fall:
    - ena and addr[7:1]==slv_addr: drive sda_oen=0, latch rw=addr[0], set addressed, go to ADDR_ACK.
    - otherwise: go to IDLE.
  - ADDR_ACK: on scl_fall, if rw=0 release SDA and go to RX. If rw=1 go to TX and present bit 7 of the buffer (see Configuration for the empty-buffer case).
  - RX: shift 8 bits on scl_rise. On the scl_fall after bit 8:
    - rx_data <= shift register, pulse rx_valid;
    - drive sda_oen=0 and go to RX_ACK.
  - RX_ACK: on scl_fall, release SDA and go to RX.
  - TX: on each scl_fall, drive the next bit (sda_oen = bit value). On the scl_fall after bit 0, release SDA and go to TX_ACK.
  - TX_ACK: sample ack = ~sSDA on scl_rise. On scl_fall:
    - ack=1: go to TX and drive bit 7 of the next byte;
    - ack=0: pulse nack_rcvd, release SDA, go to IDLE.
- tx buffer:
  - becomes empty when its byte is loaded into the shift register;
  - tx_req = buffer empty & addressed & rw;
  - tx_valid always overwrites the buffer and marks it full, even when tx_req is low.
- busy: set on START, cleared on STOP.

## Timing
- Reset values:
  - scl_oen=1, sda_oen=1;
  - rx_data=0, rx_valid=0, tx_req=0, busy=0, addressed=0, rw=0, nack_rcvd=0;
  - state IDLE, tx buffer empty.
- Reset in mid-transfer releases both lines immediately (asynchronous).
- Latency from a bus edge on scl_i/sda_i to the detect signal: 2 clk. sda_oen changes on the clk edge after detection, i.e. 3 clk after the SCL falling edge reaches scl_i.
- clk must be at least 16x the SCL frequency. The master's SDA hold time must cover the 3-clk reaction.
- rx_valid is asserted in the same cycle that ACK drive begins (sda_oen goes 1 to 0).
- Mismatched address: sda_oen and scl_oen stay at 1 for the whole transfer.

## Configuration
- I2C_SLAVE_STRETCH_EN defined:
  - On entry to TX with the buffer empty, hold scl_oen=0 until tx_valid.
  - Load the byte, drive bit 7, wait SU_CYC cycles, then release SCL (scl_oen=1).
  - START or STOP during a stretch releases SCL immediately.
- I2C_SLAVE_STRETCH_EN undefined:
  - scl_oen is constant 1 and SU_CYC is unused.
  - On entry to TX with the buffer empty, transmit 0xFF (SDA released).

## Test plan
- Write 0x3A to address 0x50 (slv_addr=0x50, ena=1): address ACK, rx_valid once with rx_data=0x3A, SDA pulled low in both ACK slots, busy and addressed drop after STOP.
- Read from 0x50 with tx_data=0xA5 preloaded, master ACKs then NACKs: bus carries 0xA5, then 0xC3 supplied on tx_req; one nack_rcvd pulse; state returns to IDLE.
- Write to address 0x51, then ena=0 with address 0x50: sda_oen stays 1 throughout, busy toggles, addressed stays 0.
- Stretch build, read with buffer empty: scl_oen=0 until tx_valid (0x5C). scl_oen returns to 1 exactly SU_CYC+1 cycles after tx_valid. The byte received is 0x5C.
- Non-stretch build, read with buffer empty: master receives 0xFF and scl_oen is never 0.
- Repeated START after write byte 0x11, then read address 0x50: rw=1, second phase transmits the buffered byte. Assert rst mid-byte: sda_oen and scl_oen go to 1 asynchronously.
